// File: rtl/x2050_dcbs_seq.sv
// Byte-serial decimal sequencer: walks a one-hot byte select across words and chains byte carries.
// Optional all-zero result tracking is enabled with the X2050_DCBS_ZERO_DETECT_EN macro.
module x2050_dcbs_seq (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [1:0] i_byte,
    input  logic [3:0] i_len,
    input  logic       i_dir,
    input  logic       i_step,
    input  logic       i_cx_bs,
    input  logic       i_abort,
    input  logic       i_byte_zero,
    output logic [3:0] o_bs_reg,
    output logic       o_carry_in,
    output logic       o_busy,
    output logic       o_last,
    output logic       o_word_adv,
    output logic       o_done,
    output logic       o_all_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state_q;
    logic [1:0] index_q;
    logic [1:0] index_d;
    logic [3:0] count_q;
    logic       dir_q;
    logic       carry_q;
    logic       wrap;

    assign index_d = dir_q ? (index_q + 2'd1) : (index_q - 2'd1);
    assign wrap    = dir_q ? (index_q == 2'd3) : (index_q == 2'd0);

`ifdef X2050_DCBS_ZERO_DETECT_EN
    logic zero_q;
`else
    logic unused_byte_zero;
    assign unused_byte_zero = i_byte_zero;
`endif

    // Abort takes priority over a step; the final step latches carry without moving the index.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
            index_q <= 2'd0;
            count_q <= 4'd0;
            dir_q   <= 1'b0;
            carry_q <= 1'b0;
`ifdef X2050_DCBS_ZERO_DETECT_EN
            zero_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        state_q <= RUN;
                        index_q <= i_byte;
                        count_q <= i_len;
                        dir_q   <= i_dir;
                        carry_q <= 1'b0;
`ifdef X2050_DCBS_ZERO_DETECT_EN
                        zero_q  <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    if (i_abort) begin
                        state_q <= IDLE;
                    end else if (i_step) begin
                        carry_q <= i_cx_bs;
`ifdef X2050_DCBS_ZERO_DETECT_EN
                        zero_q  <= zero_q & i_byte_zero;
`endif
                        if (count_q == 4'd0) begin
                            state_q <= DONE;
                        end else begin
                            count_q <= count_q - 4'd1;
                            index_q <= index_d;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Byte n maps to mask bit (3-n), so index 0 is the leftmost byte.
    assign o_bs_reg   = (state_q == RUN) ? (4'b1000 >> index_q) : 4'b0000;
    assign o_carry_in = carry_q;
    assign o_busy     = (state_q == RUN);
    assign o_last     = (state_q == RUN) && (count_q == 4'd0);
    assign o_word_adv = (state_q == RUN) && i_step && !i_abort && (count_q != 4'd0) && wrap;
    assign o_done     = (state_q == DONE);

`ifdef X2050_DCBS_ZERO_DETECT_EN
    assign o_all_zero = zero_q;
`else
    assign o_all_zero = 1'b0;
`endif

endmodule

// File: tb/tb_x2050_dcbs_seq.sv
// Directed self-checking bench for x2050_dcbs_seq with hand-computed expectations.
// Expectations for o_all_zero follow X2050_DCBS_ZERO_DETECT_EN when that macro is defined.
module tb_x2050_dcbs_seq;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] byteIdx;
    logic [3:0] len;
    logic       dir;
    logic       step;
    logic       cxBs;
    logic       abortSeq;
    logic       byteZero;
    logic [3:0] bsReg;
    logic       carryIn;
    logic       busy;
    logic       last;
    logic       wordAdv;
    logic       done;
    logic       allZero;

    int checkCount = 0;
    int passCount  = 0;

`ifdef X2050_DCBS_ZERO_DETECT_EN
    localparam logic ZD = 1'b1;
`else
    localparam logic ZD = 1'b0;
`endif

    x2050_dcbs_seq dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_byte      (byteIdx),
        .i_len       (len),
        .i_dir       (dir),
        .i_step      (step),
        .i_cx_bs     (cxBs),
        .i_abort     (abortSeq),
        .i_byte_zero (byteZero),
        .o_bs_reg    (bsReg),
        .o_carry_in  (carryIn),
        .o_busy      (busy),
        .o_last      (last),
        .o_word_adv  (wordAdv),
        .o_done      (done),
        .o_all_zero  (allZero)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts every comparison and reports the ones that disagree.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) passCount++;
        else $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Drives all functional inputs in one go.
    task automatic applyStimulus(input logic st, input logic [1:0] b, input logic [3:0] l, input logic d,
                                 input logic sp, input logic cx, input logic ab, input logic bz);
        start = st; byteIdx = b; len = l; dir = d; step = sp; cxBs = cx; abortSeq = ab; byteZero = bz;
    endtask

    // Advances one clock and lands just after the edge so outputs have settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks every output against its post-reset value.
    task automatic checkResetState(input string tag);
        checkOutput({tag, ".bs"},   bsReg,   4'b0000);
        checkOutput({tag, ".cin"},  carryIn, 1'b0);
        checkOutput({tag, ".busy"}, busy,    1'b0);
        checkOutput({tag, ".last"}, last,    1'b0);
        checkOutput({tag, ".adv"},  wordAdv, 1'b0);
        checkOutput({tag, ".done"}, done,    1'b0);
        checkOutput({tag, ".az"},   allZero, ZD);
    endtask

    logic [3:0] bs33 [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic       cin33[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       cx33 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [3:0] bs34 [6] = '{4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic       adv34[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       bz37 [3] = '{1'b1, 1'b0, 1'b1};
    logic       az37 [3] = '{1'b1, 1'b0, 1'b0};

    // Directed scenarios run back to back from a single reset.
    initial begin
        int advSeen;
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;
        checkResetState("reset");

        // Step and abort are ignored while idle.
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0);
        tick();
        checkOutput("idle.busy", busy, 1'b0);
        checkOutput("idle.cin", carryIn, 1'b0);

        // Right-to-left across one word with a carry pattern.
        applyStimulus(1, 2'd3, 4'd3, 0, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        checkOutput("r2l.busy", busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("r2l.bs%0d", i), bsReg, bs33[i]);
            checkOutput($sformatf("r2l.cin%0d", i), carryIn, cin33[i]);
            checkOutput($sformatf("r2l.last%0d", i), last, (i == 3));
            step = 1'b1; cxBs = cx33[i];
            #1;
            checkOutput($sformatf("r2l.adv%0d", i), wordAdv, 1'b0);
            tick();
        end
        step = 1'b0;
        checkOutput("r2l.done", done, 1'b1);
        checkOutput("r2l.bsDone", bsReg, 4'b0000);
        checkOutput("r2l.cinDone", carryIn, 1'b1);
        // Start is ignored in the DONE cycle.
        start = 1'b1;
        tick();
        start = 1'b0;
        checkOutput("r2l.doneOnce", done, 1'b0);
        checkOutput("r2l.idle", busy, 1'b0);
        checkOutput("r2l.cinHeld", carryIn, 1'b1);

        // Wrap from byte 0 back to byte 3 of the next word.
        applyStimulus(1, 2'd1, 4'd5, 0, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        checkOutput("wrap.cinStart", carryIn, 1'b0);
        advSeen = 0;
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("wrap.bs%0d", i), bsReg, bs34[i]);
            step = 1'b1;
            #1;
            checkOutput($sformatf("wrap.adv%0d", i), wordAdv, adv34[i]);
            if (wordAdv) advSeen++;
            tick();
        end
        step = 1'b0;
        checkOutput("wrap.advCount", advSeen, 1);
        checkOutput("wrap.done", done, 1'b1);
        tick();

        // Abort wins over a simultaneous step that would also wrap.
        applyStimulus(1, 2'd2, 4'd2, 1, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        checkOutput("abort.bs0", bsReg, 4'b0010);
        step = 1'b1;
        tick();
        checkOutput("abort.bs1", bsReg, 4'b0001);
        abortSeq = 1'b1;
        #1;
        checkOutput("abort.adv", wordAdv, 1'b0);
        tick();
        step = 1'b0; abortSeq = 1'b0;
        checkOutput("abort.bs", bsReg, 4'b0000);
        checkOutput("abort.busy", busy, 1'b0);
        checkOutput("abort.done", done, 1'b0);
        tick();
        checkOutput("abort.doneLater", done, 1'b0);

        // Reset mid-run, then a normal short sequence.
        applyStimulus(1, 2'd0, 4'd4, 1, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        checkOutput("rst.busy", busy, 1'b1);
        checkOutput("rst.last", last, 1'b0);
        step = 1'b1; cxBs = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0; step = 1'b0;
        checkResetState("rst");
        applyStimulus(1, 2'd0, 4'd1, 1, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        checkOutput("rst.bsA", bsReg, 4'b1000);
        step = 1'b1; cxBs = 1'b1;
        tick();
        checkOutput("rst.bsB", bsReg, 4'b0100);
        checkOutput("rst.lastB", last, 1'b1);
        checkOutput("rst.cinB", carryIn, 1'b1);
        cxBs = 1'b0;
        tick();
        step = 1'b0;
        checkOutput("rst.done", done, 1'b1);
        checkOutput("rst.cinDone", carryIn, 1'b0);
        tick();

        // Zero tracking across three bytes.
        applyStimulus(1, 2'd0, 4'd2, 1, 0, 0, 0, 0);
        tick();
        start = 1'b0;
        checkOutput("zero.start", allZero, ZD);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1; byteZero = bz37[i];
            tick();
            checkOutput($sformatf("zero.step%0d", i), allZero, ZD & az37[i]);
        end
        step = 1'b0; byteZero = 1'b1;
        checkOutput("zero.done", done, 1'b1);
        tick();
        tick();
        checkOutput("zero.held", allZero, 1'b0);

        // Single-byte field held for several cycles before its only step.
        applyStimulus(1, 2'd2, 4'd0, 0, 0, 1, 0, 0);
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("one.last%0d", i), last, 1'b1);
            checkOutput($sformatf("one.bs%0d", i), bsReg, 4'b0010);
            checkOutput($sformatf("one.cin%0d", i), carryIn, 1'b0);
            tick();
        end
        step = 1'b1;
        tick();
        step = 1'b0;
        checkOutput("one.done", done, 1'b1);
        checkOutput("one.cin", carryIn, 1'b1);
        tick();
        checkOutput("one.doneOnce", done, 1'b0);
        checkOutput("one.busy", busy, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
